// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared types and constants for the data-memory responder
package dm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dm_state_t;

    localparam int DM_ADDR_WORDS = 1024;
    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/dm_array.sv
// rtl/dm_array.sv - word storage with byte-enabled write, registered read, async clear
// Ports:
//   clk, reset             clock, async active-low clear of all words and rd_data
//   wr_en/wr_idx/wr_data/wr_be   byte-enabled synchronous write
//   rd_en/rd_zero/rd_idx   synchronous read; rd_zero loads 0 instead of a word
//   rd_data                registered read data, held between reads
module dm_array
    import dm_pkg::*;
#(
    parameter int ADDR_WORDS = DM_ADDR_WORDS,
    parameter int IDX_W      = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data,
    input  logic [3:0]       wr_be,
    input  logic             rd_en,
    input  logic             rd_zero,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data
);

    logic [31:0] mem [ADDR_WORDS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ADDR_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_zero ? 32'd0 : mem[rd_idx];
        end
    end

endmodule

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - fixed-latency load/store responder with pipeline stall
// Ports:
//   clk, reset        clock, async active-low reset
//   req, we           request valid, 1 = store
//   addr, wdata, be   byte address (word = addr[31:2]), store data, byte enables
//   stall             freeze pipeline while a request is being serviced
//   rvalid            one-cycle completion pulse
//   rdata             last loaded word, held until the next load commit
//   err               out-of-range access, meaningful with rvalid
module dm_responder
    import dm_pkg::*;
#(
    parameter int ADDR_WORDS = DM_ADDR_WORDS,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        stall,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int          IDX_W   = (ADDR_WORDS > 1) ? $clog2(ADDR_WORDS) : 1;
    localparam logic [31:0] DEPTH   = 32'(ADDR_WORDS);
    localparam logic [3:0]  LAT_CNT = 4'(LATENCY);

    dm_state_t   state;
    logic [3:0]  cnt;
    logic        q_we;
    logic [29:0] q_idx;
    logic [31:0] q_wdata;
    logic [3:0]  q_be;

    logic        in_range;
    logic        commit;
    logic        unused_addr_lsbs;

    // Byte lane bits never select anything; the MEM stage already aligned the data.
    assign unused_addr_lsbs = ^addr[1:0];

    assign in_range = ({2'b00, q_idx} < DEPTH);
    assign commit   = (state == WAIT) && (cnt == 4'd1);
    // Combinational from req only in IDLE so the accept cycle is already frozen.
    assign stall    = ((state == IDLE) && req) || (state == WAIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            q_we    <= 1'b0;
            q_idx   <= '0;
            q_wdata <= '0;
            q_be    <= '0;
            rvalid  <= 1'b0;
            err     <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        q_we    <= we;
                        q_idx   <= addr[31:2];
                        q_wdata <= wdata;
                        q_be    <= we ? be : BE_WORD;
                        cnt     <= LAT_CNT;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        state  <= DONE;
                        rvalid <= 1'b1;
                        err    <= !in_range;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                // A req still visible here belongs to the instruction just serviced.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    dm_array #(
        .ADDR_WORDS (ADDR_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (commit && q_we && in_range),
        .wr_idx  (q_idx[IDX_W-1:0]),
        .wr_data (q_wdata),
        .wr_be   (q_be),
        .rd_en   (commit && !q_we),
        .rd_zero (!in_range),
        .rd_idx  (q_idx[IDX_W-1:0]),
        .rd_data (rdata)
    );

endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - scoreboard bench for dm_responder with a word-array reference model
module tb_dm_responder;

    localparam int WORDS = 1024;
    localparam int LAT_A = 2;
    localparam int LAT_B = 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        req_a = 1'b0, we_a = 1'b0;
    logic [31:0] addr_a = '0, wdata_a = '0;
    logic [3:0]  be_a = '0;
    logic        stall_a, rvalid_a, err_a;
    logic [31:0] rdata_a;

    logic        req_b = 1'b0, we_b = 1'b0;
    logic [31:0] addr_b = '0, wdata_b = '0;
    logic [3:0]  be_b = '0;
    logic        stall_b, rvalid_b, err_b;
    logic [31:0] rdata_b;

    int checks = 0;
    int errors = 0;

    exp_t        sb_q[$];
    exp_t        got;
    logic [31:0] model_mem [WORDS];
    logic [31:0] last_rdata;

    always #5 clk = ~clk;

    dm_responder #(.ADDR_WORDS(WORDS), .LATENCY(LAT_A)) u_dut (
        .clk(clk), .reset(reset), .req(req_a), .we(we_a), .addr(addr_a),
        .wdata(wdata_a), .be(be_a), .stall(stall_a), .rvalid(rvalid_a),
        .rdata(rdata_a), .err(err_a)
    );

    dm_responder #(.ADDR_WORDS(WORDS), .LATENCY(LAT_B)) u_dut_lat1 (
        .clk(clk), .reset(reset), .req(req_b), .we(we_b), .addr(addr_b),
        .wdata(wdata_b), .be(be_b), .stall(stall_b), .rvalid(rvalid_b),
        .rdata(rdata_b), .err(err_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < WORDS; i++) model_mem[i] = '0;
        last_rdata = '0;
    endtask

    // Reference: a plain word array; memory effect and response decided at issue time.
    task automatic model_push(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] b);
        exp_t e;
        int unsigned idx;
        bit inr;
        idx = a >> 2;
        inr = (idx < WORDS);
        if (w) begin
            if (inr) begin
                for (int k = 0; k < 4; k++)
                    if (b[k]) model_mem[idx][8*k +: 8] = d[8*k +: 8];
            end
        end else begin
            last_rdata = inr ? model_mem[idx] : 32'd0;
        end
        e.rdata = last_rdata;
        e.err   = !inr;
        sb_q.push_back(e);
    endtask

    // Starts at the cycle after the previous call, so consecutive calls keep req high.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b);
        int n;
        @(posedge clk); #1;
        req_a = 1'b1; we_a = w; addr_a = a; wdata_a = d; be_a = b;
        model_push(w, a, d, b);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (stall_a) n++;
            else break;
        end
        check("a_stall_cycles", 32'(n), 32'(LAT_A + 1));
        check("a_rvalid_at_release", {31'd0, rvalid_a}, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            req_a = 1'b0;
            addr_a = $urandom;
        end
    endtask

    task automatic issue_b(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] b, input logic [31:0] exp_rd, input logic exp_err);
        int n;
        @(posedge clk); #1;
        req_b = 1'b1; we_b = w; addr_b = a; wdata_b = d; be_b = b;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (stall_b) n++;
            else break;
        end
        check("b_stall_cycles", 32'(n), 32'(LAT_B + 1));
        check("b_rvalid", {31'd0, rvalid_b}, 32'd1);
        check("b_rdata", rdata_b, exp_rd);
        check("b_err", {31'd0, err_b}, {31'd0, exp_err});
        @(posedge clk); #1;
        req_b = 1'b0;
        @(negedge clk);
        check("b_rvalid_single", {31'd0, rvalid_b}, 32'd0);
    endtask

    // Monitor: every completion pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset && rvalid_a) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_rvalid actual=1 expected=0 rdata=%h", rdata_a);
            end else begin
                got = sb_q.pop_front();
                check("a_rdata", rdata_a, got.rdata);
                check("a_err", {31'd0, err_a}, {31'd0, got.err});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        model_clear();
        #3;
        check("rst_stall", {31'd0, stall_a}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid_a}, 32'd0);
        check("rst_rdata", rdata_a, 32'd0);
        check("rst_err", {31'd0, err_a}, 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;

        // One-edge latency instance
        issue_b(1'b0, 32'h14, 32'h0, 4'hF, 32'd0, 1'b0);
        issue_b(1'b1, 32'h14, 32'h12345678, 4'hF, 32'd0, 1'b0);
        issue_b(1'b0, 32'h14, 32'h0, 4'hF, 32'h12345678, 1'b0);
        issue_b(1'b0, 32'h1000, 32'h0, 4'hF, 32'd0, 1'b1);

        // Directed accesses on the two-edge instance
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111); idle(1);
        issue(1'b0, 32'h10, 32'h0, 4'b0000);        idle(1);
        issue(1'b1, 32'h10, 32'h0000AA00, 4'b0010); idle(1);
        issue(1'b0, 32'h10, 32'h0, 4'b0000);        idle(2);
        issue(1'b0, 32'h14, 32'h0, 4'b0000);        idle(1);
        issue(1'b0, 32'h1000, 32'h0, 4'b0000);      idle(1);
        issue(1'b1, 32'h1000, 32'hFFFFFFFF, 4'b1111); idle(1);
        issue(1'b0, 32'h0, 32'h0, 4'b0000);         idle(1);
        issue(1'b1, 32'hFFC, 32'hCAFEF00D, 4'b1111); idle(1);
        issue(1'b0, 32'hFFC, 32'h0, 4'b0000);       idle(1);
        // Held req across two back-to-back loads
        issue(1'b0, 32'h10, 32'h0, 4'b0000);
        issue(1'b0, 32'hFFC, 32'h0, 4'b0000);
        issue(1'b1, 32'h8, 32'h01020304, 4'b0101);
        issue(1'b0, 32'h8, 32'h0, 4'b0000);         idle(2);

        // Reset while a store to 0x20 waits
        @(posedge clk); #1;
        req_a = 1'b1; we_a = 1'b1; addr_a = 32'h20; wdata_a = 32'h55AA55AA; be_a = 4'hF;
        @(posedge clk); #1;
        check("abort_wait_stall", {31'd0, stall_a}, 32'd1);
        reset = 1'b0;
        req_a = 1'b0;
        #1;
        check("abort_stall", {31'd0, stall_a}, 32'd0);
        check("abort_rvalid", {31'd0, rvalid_a}, 32'd0);
        check("abort_rdata", rdata_a, 32'd0);
        check("abort_err", {31'd0, err_a}, 32'd0);
        model_clear();
        repeat (3) @(negedge clk);
        check("abort_no_rvalid", {31'd0, rvalid_a}, 32'd0);
        check("abort_idle", {31'd0, stall_a}, 32'd0);
        reset = 1'b1;
        issue(1'b0, 32'h20, 32'h0, 4'b0000);        idle(1);
        issue(1'b0, 32'h10, 32'h0, 4'b0000);        idle(1);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: a = 32'($urandom_range(0, 63));
                6:       a = 32'hFFC | 32'($urandom_range(0, 3));
                7:       a = 32'h1000 | 32'($urandom_range(0, 3));
                default: a = $urandom;
            endcase
            issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
        end

        idle(4);
        @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
